uart_tx_arbiter: RTL and testbench

Shares the single UART transmit path between up to `N_REQ` requesters. It arbitrates round-robin at packet granularity and feeds bytes one at a time on `tx_in`/`tx_write`. The transmitter has no done flag, so the block paces bytes with an internal frame-time counter. It sits between the application logic and the `tx_in`/`tx_write` inputs of the UART top.

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, pacing defaults
// and the index-width helper used by the top and the round-robin selector.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // 10-bit frame at 50 MHz plus margin: 52083 -> 57600 (9600 bd), 4340 -> 4800 (115200 bd)
    localparam int BYTE_CYCLES_9600   = 57600;
    localparam int BYTE_CYCLES_115200 = 4800;
    localparam int PULSE_CYCLES_DEF   = 2;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first requester found scanning upward
// from the index after last_owner wins.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx,
    output logic             found
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, last_owner} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter; bytes are paced
// by a frame-time counter because the transmitter reports no completion.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BYTE_CYCLES  = BYTE_CYCLES_9600,
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_in,
    output logic               tx_write,
    output logic               busy
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = $clog2(BYTE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM   = CW'(BYTE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_TERM = CW'(PULSE_CYCLES - 1);

    state_t           state_reg;
    logic [IW-1:0]    owner_reg;
    logic [IW-1:0]    last_owner_reg;
    logic [CW-1:0]    cnt_reg;
    logic             last_flag_reg;
    logic [7:0]       tx_in_reg;
    logic             tx_write_reg;
    logic [N_REQ-1:0] grant_reg;

    logic [7:0]       data_arr [N_REQ];
    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic             win_found;
    logic             owner_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req        (req),
        .last_owner (last_owner_reg),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .found      (win_found)
    );

    assign owner_req = req[owner_reg];
    assign ack       = (state_reg == ST_LOAD && owner_req) ? grant_reg : '0;
    assign grant     = grant_reg;
    assign tx_in     = tx_in_reg;
    assign tx_write  = tx_write_reg;
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IW'(N_REQ - 1);
            cnt_reg        <= '0;
            last_flag_reg  <= 1'b0;
            tx_in_reg      <= 8'h00;
            tx_write_reg   <= 1'b0;
            grant_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_reg <= win_onehot;
                        owner_reg <= win_idx;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (owner_req) begin
                        tx_in_reg     <= data_arr[owner_reg];
                        last_flag_reg <= req_last[owner_reg];
                        cnt_reg       <= '0;
                        tx_write_reg  <= 1'b1;
                        state_reg     <= ST_STROBE;
                    end else begin
                        // owner withdrew mid-packet: close it without sending
                        grant_reg      <= '0;
                        last_owner_reg <= owner_reg;
                        state_reg      <= ST_IDLE;
                    end
                end
                ST_STROBE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == PULSE_TERM) begin
                        tx_write_reg <= 1'b0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != CNT_TERM) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (last_flag_reg) begin
                        grant_reg      <= '0;
                        last_owner_reg <= owner_reg;
                        state_reg      <= ST_IDLE;
                    end else begin
                        state_reg <= ST_LOAD;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised requester traffic against a timeline model of the arbiter, with a
// byte scoreboard and directed scenarios pinned by literal expectations.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int B = 20;
    localparam int P = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, req_last, ack, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_in;
    logic           tx_write, busy;

    uart_tx_arbiter #(.N_REQ(N), .BYTE_CYCLES(B), .PULSE_CYCLES(P)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .grant(grant), .tx_in(tx_in), .tx_write(tx_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;
    bit rel_pending = 0;

    // requester drivers
    bit         active [N];
    int         pos [N], len [N], abort_at [N], gap_cnt [N];
    logic [7:0] pbytes [N][8];
    bit         auto_mode = 0;
    int         rnd_maxlen = 1, rnd_maxgap = 0, rnd_abort_pct = 0;

    // timeline model: a packet is open from its first LOAD; each byte occupies B+1 cycles
    bit         m_open;
    int         m_owner, m_last, m_load, cur_d;
    logic [7:0] m_txin;
    bit         m_lastf;
    logic [N-1:0] m_ack_prev;

    // observation records and scoreboard
    int ack_cyc_q[$], ack_vec_q[$], ack_gnt_q[$], rise_cyc_q[$], rise_byte_q[$];
    int busy_fall_q[$], gopen_q[$];
    int sb[$];
    int txw_high, last_rise;
    logic prev_txw, prev_busy;
    logic [N-1:0] prev_grant;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_records();
        ack_cyc_q.delete(); ack_vec_q.delete(); ack_gnt_q.delete();
        rise_cyc_q.delete(); rise_byte_q.delete(); busy_fall_q.delete(); gopen_q.delete();
        txw_high = 0;
    endtask

    task automatic model_reset();
        m_open = 0; m_owner = 0; m_last = N-1; m_load = 0; m_txin = 8'h00; m_lastf = 0;
        m_ack_prev = '0; cur_d = -1;
        sb.delete(); last_rise = -1000;
        prev_txw = 0; prev_busy = 0; prev_grant = '0;
    endtask

    task automatic set_pkt(input int i, input int l, input int ab,
                           input logic [7:0] b0, b1, b2, b3);
        active[i] = 1; pos[i] = 0; len[i] = l; abort_at[i] = ab;
        pbytes[i][0] = b0; pbytes[i][1] = b1; pbytes[i][2] = b2; pbytes[i][3] = b3;
    endtask

    task automatic new_random_pkt(input int i);
        active[i] = 1; pos[i] = 0;
        len[i] = $urandom_range(1, rnd_maxlen);
        abort_at[i] = (len[i] > 1 && $urandom_range(0, 99) < rnd_abort_pct) ?
                      $urandom_range(1, len[i]-1) : 0;
        for (int k = 0; k < 8; k++) pbytes[i][k] = 8'($urandom);
    endtask

    task automatic model_cycle();
        int d, c;
        bit found;
        logic [N-1:0] e_grant, e_ack;
        logic e_txw;
        if (!rst_n) begin
            chk("rst_grant", grant, 0); chk("rst_ack", ack, 0); chk("rst_tx_write", tx_write, 0);
            chk("rst_busy", busy, 0); chk("rst_tx_in", tx_in, 8'h00);
            return;
        end
        d = m_open ? tcyc - m_load : -1;
        cur_d = d;
        e_grant = m_open ? (N'(1) << m_owner) : '0;
        e_ack   = (m_open && d == 0 && req[m_owner]) ? e_grant : '0;
        e_txw   = m_open && d >= 1 && d <= P;
        chk("grant", grant, e_grant);
        chk("ack", ack, e_ack);
        chk("tx_write", tx_write, e_txw);
        chk("busy", busy, m_open);
        chk("tx_in", tx_in, m_txin);

        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                sb.push_back(int'(req_data[8*i +: 8]));
                ack_cyc_q.push_back(tcyc); ack_vec_q.push_back(int'(ack));
                ack_gnt_q.push_back(int'(grant));
                $display("cycle %0d: ack requester %0d byte %02h", tcyc, i, req_data[8*i +: 8]);
            end
        end
        if (tx_write && !prev_txw) begin
            rise_cyc_q.push_back(tcyc); rise_byte_q.push_back(int'(tx_in));
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_extra_rise: tx_write rise with byte %02h but no ack pending", tx_in);
            end else begin
                chk("sb_byte", tx_in, sb.pop_front());
            end
            if (last_rise > -1000) chk("rise_spacing_ge_B", (tcyc - last_rise) >= B, 1);
            last_rise = tcyc;
        end
        if (tx_write) txw_high++;
        if (prev_busy && !busy) busy_fall_q.push_back(tcyc);
        if (prev_grant == 0 && grant != 0) gopen_q.push_back(int'(grant));
        prev_txw = tx_write; prev_busy = busy; prev_grant = grant;

        m_ack_prev = e_ack;
        if (!m_open) begin
            if (req != 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && req[c]) begin found = 1; m_owner = c; end
                end
                m_open = 1; m_load = tcyc + 1;
            end
        end else if (d == 0) begin
            if (req[m_owner]) begin
                m_txin = req_data[8*m_owner +: 8]; m_lastf = req_last[m_owner];
            end else begin
                m_open = 0; m_last = m_owner;
            end
        end else if (d == B) begin
            if (m_lastf) begin m_open = 0; m_last = m_owner; end
            else m_load = tcyc + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        tcyc++;
        for (int i = 0; i < N; i++) begin
            if (m_ack_prev[i] && active[i]) begin
                pos[i]++;
                if (pos[i] == len[i] || pos[i] == abort_at[i]) begin
                    active[i] = 0; gap_cnt[i] = $urandom_range(0, rnd_maxgap);
                end
            end
            if (auto_mode && !active[i]) begin
                if (gap_cnt[i] > 0) gap_cnt[i]--;
                else new_random_pkt(i);
            end
            req[i]      = active[i];
            req_last[i] = active[i] && (pos[i] == len[i] - 1);
            req_data[8*i +: 8] = (active[i] && pos[i] < 8) ? pbytes[i][pos[i]] : 8'($urandom);
        end
        @(negedge clk);
        if (rel_pending) begin rst_n = 1; rel_pending = 0; end
        model_cycle();
    endtask

    task automatic wait_quiet(input int max);
        int n = 0;
        bit any;
        do begin
            tick(); n++;
            any = 0;
            for (int i = 0; i < N; i++) any |= active[i];
        end while ((any || m_open || busy) && n < max);
        chk("quiet_within_budget", n < max, 1);
    endtask

    task automatic do_reset(output int rel);
        rst_n = 0; #1;
        chk("async_rst_grant", grant, 0); chk("async_rst_tx_write", tx_write, 0);
        chk("async_rst_busy", busy, 0); chk("async_rst_tx_in", tx_in, 8'h00);
        chk("async_rst_ack", ack, 0);
        $display("cycle %0d: reset asserted", tcyc);
        model_reset(); clear_records();
        tick();
        rel_pending = 1;
        tick();
        rel = tcyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, n;
        rst_n = 0; req = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin active[i] = 0; pos[i] = 0; len[i] = 0; abort_at[i] = 0; gap_cnt[i] = 0; end
        model_reset(); clear_records();
        tick(); tick();
        rel_pending = 1;
        tick();
        chk("post_reset_grant", grant, 0); chk("post_reset_busy", busy, 0);

        // single byte
        clear_records();
        set_pkt(0, 1, 0, 8'hA5, 8'h00, 8'h00, 8'h00);
        wait_quiet(200);
        chk("t1_ack_count", ack_cyc_q.size(), 1);
        chk("t1_grant", qget(ack_gnt_q, 0), 4'b0001);
        chk("t1_byte", qget(rise_byte_q, 0), 8'hA5);
        chk("t1_pulse_width", txw_high, 2);
        chk("t1_idle_after_ack", qget(busy_fall_q, 0) - qget(ack_cyc_q, 0), 21);

        // 3-byte packet from requester 2
        clear_records();
        set_pkt(2, 3, 0, 8'h01, 8'h02, 8'h03, 8'h00);
        wait_quiet(300);
        chk("t2_ack_count", ack_cyc_q.size(), 3);
        chk("t2_space01", qget(ack_cyc_q, 1) - qget(ack_cyc_q, 0), 21);
        chk("t2_space12", qget(ack_cyc_q, 2) - qget(ack_cyc_q, 1), 21);
        for (int k = 0; k < 3; k++) begin
            chk("t2_byte", qget(rise_byte_q, k), k + 1);
            chk("t2_grant", qget(ack_gnt_q, k), 4'b0100);
        end

        // contention from reset; requester 0 opens with a 2-byte packet
        set_pkt(0, 2, 0, 8'h30, 8'h31, 8'h00, 8'h00);
        set_pkt(1, 1, 0, 8'h41, 8'h00, 8'h00, 8'h00);
        set_pkt(2, 1, 0, 8'h52, 8'h00, 8'h00, 8'h00);
        set_pkt(3, 1, 0, 8'h63, 8'h00, 8'h00, 8'h00);
        rnd_maxlen = 1; rnd_maxgap = 0; rnd_abort_pct = 0; auto_mode = 1;
        do_reset(rel);
        n = 0;
        while (gopen_q.size() < 5 && n < 1000) begin tick(); n++; end
        chk("t3_opens_within_budget", n < 1000, 1);
        auto_mode = 0;
        wait_quiet(1000);
        chk("t3_open0", qget(gopen_q, 0), 4'b0001);
        chk("t3_open1", qget(gopen_q, 1), 4'b0010);
        chk("t3_open2", qget(gopen_q, 2), 4'b0100);
        chk("t3_open3", qget(gopen_q, 3), 4'b1000);
        chk("t3_open4", qget(gopen_q, 4), 4'b0001);
        chk("t3_no_interleave_a1", qget(ack_vec_q, 1), 4'b0001);
        chk("t3_no_interleave_a2", qget(ack_vec_q, 2), 4'b0010);

        // abort: requester 3 drops req after its first byte
        clear_records();
        set_pkt(3, 3, 1, 8'h71, 8'h72, 8'h73, 8'h00);
        n = 0;
        while (ack_cyc_q.size() < 1 && n < 100) begin tick(); n++; end
        chk("t4_first_ack_within_budget", n < 100, 1);
        set_pkt(0, 1, 0, 8'h81, 8'h00, 8'h00, 8'h00);
        set_pkt(1, 1, 0, 8'h91, 8'h00, 8'h00, 8'h00);
        wait_quiet(400);
        chk("t4_open0", qget(gopen_q, 0), 4'b1000);
        chk("t4_open1", qget(gopen_q, 1), 4'b0001);
        chk("t4_open2", qget(gopen_q, 2), 4'b0010);
        chk("t4_ack_after_abort", qget(ack_vec_q, 1), 4'b0001);
        chk("t4_abort_gap", qget(ack_cyc_q, 1) - qget(ack_cyc_q, 0), 23);
        chk("t4_rise_count", rise_cyc_q.size(), 3);

        // reset in WAIT at counter 10
        set_pkt(1, 4, 0, 8'h10, 8'h11, 8'h12, 8'h13);
        n = 0;
        while (cur_d != 11 && n < 200) begin tick(); n++; end
        chk("t5_reach_wait_within_budget", n < 200, 1);
        do_reset(rel);
        wait_quiet(400);
        chk("t5_first_rise", qget(rise_cyc_q, 0) - rel, 2);
        chk("t5_no_resend", qget(rise_byte_q, 0), 8'h11);
        chk("t5_ack_count", ack_cyc_q.size(), 3);

        // random traffic with aborts and gaps
        clear_records();
        rnd_maxlen = 4; rnd_maxgap = 30; rnd_abort_pct = 25; auto_mode = 1;
        repeat (3000) tick();
        auto_mode = 0;
        wait_quiet(2000);
        chk("rand_acks_equal_rises", ack_cyc_q.size(), rise_cyc_q.size());
        chk("sb_leftover", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
